// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone classic arbiter for NUM_M masters sharing one slave port.
// The grant is locked for the whole CYC window; a watchdog aborts unacked strobes.
module wb_bus_arbiter #(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NUM_M-1:0]     i_m_cyc,
  input  logic [NUM_M-1:0]     i_m_stb,
  input  logic [NUM_M-1:0]     i_m_we,
  input  logic [NUM_M*32-1:0]  i_m_adr,
  input  logic [NUM_M*32-1:0]  i_m_dat,
  input  logic [NUM_M*4-1:0]   i_m_sel,
  output logic [31:0]          o_m_dat,
  output logic [NUM_M-1:0]     o_m_ack,
  output logic [NUM_M-1:0]     o_m_err,
  output logic [NUM_M-1:0]     o_grant,
  output logic                 o_s_cyc,
  output logic                 o_s_stb,
  output logic                 o_s_we,
  output logic [31:0]          o_s_adr,
  output logic [31:0]          o_s_dat,
  output logic [3:0]           o_s_sel,
  input  logic [31:0]          i_s_dat,
  input  logic                 i_s_ack
);

  localparam int LW = $clog2(NUM_M);
  localparam logic [CNT_W-1:0] WDT_LAST =
    CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_M - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_t;

  state_t           state_q, state_d;
  logic [NUM_M-1:0] grant_d;
  logic [LW-1:0]    last_q, last_d;
  logic [LW-1:0]    gidx, scan_idx, win_idx;
  logic [CNT_W-1:0] wdt_q, wdt_d;
  logic             found;
  logic             cyc_g, stb_g;
  logic             wdt_hit;

  logic [31:0] adr_a [NUM_M];
  logic [31:0] dat_a [NUM_M];
  logic [3:0]  sel_a [NUM_M];

  for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
    assign adr_a[i] = i_m_adr[32*i +: 32];
    assign dat_a[i] = i_m_dat[32*i +: 32];
    assign sel_a[i] = i_m_sel[4*i +: 4];
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (o_grant[i]) gidx = LW'(i);
    end
  end

  assign cyc_g = i_m_cyc[gidx];
  assign stb_g = i_m_stb[gidx];

  // Ack in the same cycle beats the timeout.
  assign wdt_hit = (TIMEOUT > 0) && stb_g && !i_s_ack
                   && (wdt_q == WDT_LAST);

  // Scan starts just past the last owner, wrapping.
  always_comb begin
    found    = 1'b0;
    scan_idx = '0;
    win_idx  = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      scan_idx = LW'((int'(last_q) + i) % NUM_M);
      if (!found && i_m_cyc[scan_idx]) begin
        found   = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = o_grant;
    last_d  = last_q;
    wdt_d   = wdt_q;
    unique case (state_q)
      IDLE: begin
        wdt_d = '0;
        if (found) begin
          state_d          = BUSY;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_d           = win_idx;
        end
      end
      BUSY: begin
        if (!cyc_g) begin
          state_d = IDLE;
          grant_d = '0;
          wdt_d   = '0;
        end else if (wdt_hit) begin
          state_d = ERR;
        end else if ((TIMEOUT > 0) && stb_g && !i_s_ack) begin
          wdt_d = wdt_q + 1'b1;
        end else begin
          wdt_d = '0;
        end
      end
      ERR: begin
        if (!cyc_g) begin
          state_d = IDLE;
          grant_d = '0;
          wdt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        wdt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      o_grant <= '0;
      last_q  <= LAST_RST;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      o_grant <= grant_d;
      last_q  <= last_d;
      wdt_q   <= wdt_d;
    end
  end

  assign o_m_dat = i_s_dat;

  always_comb begin
    o_s_cyc = 1'b0;
    o_s_stb = 1'b0;
    o_s_we  = 1'b0;
    o_s_adr = '0;
    o_s_dat = '0;
    o_s_sel = '0;
    o_m_ack = '0;
    o_m_err = '0;
    if (state_q == BUSY) begin
      o_s_cyc       = cyc_g;
      o_s_stb       = stb_g;
      o_s_we        = i_m_we[gidx];
      o_s_adr       = adr_a[gidx];
      o_s_dat       = dat_a[gidx];
      o_s_sel       = sel_a[gidx];
      o_m_ack[gidx] = i_s_ack & stb_g;
      o_m_err[gidx] = wdt_hit;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios plus randomized traffic
// compared against an ownership-level reference model.
module tb_wb_bus_arbiter;

  localparam int NUM_M   = 2;
  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_adr, m_dat;
  logic [7:0]  m_sel;
  logic [31:0] o_m_dat;
  logic [1:0]  m_ack, m_err, grant;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_ack;

  int n_cmp = 0;
  int n_bad = 0;

  wb_bus_arbiter #(
    .NUM_M(NUM_M), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we),
    .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel),
    .o_m_dat(o_m_dat), .o_m_ack(m_ack), .o_m_err(m_err),
    .o_grant(grant),
    .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we),
    .o_s_adr(s_adr), .o_s_dat(s_dat_o), .o_s_sel(s_sel),
    .i_s_dat(s_dat_i), .i_s_ack(s_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout: sim did not end, want end before 1ms");
    $fatal(1, "timeout");
  end

  // Reference model: who owns the bus, how long the current strobe has
  // waited unacked, and whether the watchdog has aborted the ownership.
  int own = -1;
  int last = NUM_M - 1;
  int waited = 0;
  bit aborted = 1'b0;

  function automatic int pick(int from, logic [1:0] req);
    int k;
    pick = -1;
    for (int i = 1; i <= NUM_M; i++) begin
      k = (from + i) % NUM_M;
      if (pick < 0 && ((req >> k) & 2'b01) != 2'b00) pick = k;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own <= -1; last <= NUM_M - 1; waited <= 0; aborted <= 1'b0;
    end else if (own < 0) begin
      if (pick(last, m_cyc) >= 0) begin
        own  <= pick(last, m_cyc);
        last <= pick(last, m_cyc);
      end
      waited  <= 0;
      aborted <= 1'b0;
    end else if (((m_cyc >> own) & 2'b01) == 2'b00) begin
      own <= -1;
    end else if (!aborted) begin
      if (((m_stb >> own) & 2'b01) != 2'b00 && !s_ack) begin
        waited <= waited + 1;
        if (waited + 1 == TIMEOUT) aborted <= 1'b1;
      end else begin
        waited <= 0;
      end
    end
  end

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    s_ack = 1'b0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    go();
    go();
    rst_n = 1'b1;
    go();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    m_cyc = 2'b11; m_stb = 2'b11; m_adr = 64'h1111_2222_3333_4444;
    #3;
    n_cmp++;
    if (grant !== 2'b00) begin
      n_bad++; $display("FAIL reset_grant: got %b want 00", grant);
    end
    n_cmp++;
    if ({s_cyc, s_stb, s_we} !== 3'b000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000", {s_cyc, s_stb, s_we});
    end
    n_cmp++;
    if ({s_adr, s_dat_o, s_sel} !== 68'h0) begin
      n_bad++; $display("FAIL reset_bus: got %h want 0", {s_adr, s_dat_o, s_sel});
    end
    go(); go(); mid();
    n_cmp++;
    if ({grant, m_ack, m_err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_held: got %b want 000000", {grant, m_ack, m_err});
    end
    idle_inputs();
    go();
    rst_n = 1'b1;
    go();
  endtask

  task automatic test_single();
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
    m_adr[63:32] = 32'h2000_0000; m_sel[7:4] = 4'hf;
    mid();
    n_cmp++;
    if (s_cyc !== 1'b0) begin
      n_bad++; $display("FAIL single_latency: s_cyc got %b want 0", s_cyc);
    end
    go(); mid();
    n_cmp++;
    if ({grant, s_cyc, s_stb} !== 4'b1011) begin
      n_bad++; $display("FAIL single_grant: got %b want 1011", {grant, s_cyc, s_stb});
    end
    n_cmp++;
    if (s_adr !== 32'h2000_0000) begin
      n_bad++; $display("FAIL single_adr: got %h want 20000000", s_adr);
    end
    go(); mid();
    n_cmp++;
    if (m_ack !== 2'b00) begin
      n_bad++; $display("FAIL single_noack: got %b want 00", m_ack);
    end
    go();
    s_ack = 1'b1; s_dat_i = 32'h1234_5678;
    mid();
    n_cmp++;
    if ({m_ack, o_m_dat} !== {2'b10, 32'h1234_5678}) begin
      n_bad++; $display("FAIL single_ack: got %b/%h want 10/12345678", m_ack, o_m_dat);
    end
    go();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    mid();
    n_cmp++;
    if ({grant, s_cyc} !== 3'b100) begin
      n_bad++; $display("FAIL single_drop: got %b want 100", {grant, s_cyc});
    end
    go(); mid();
    n_cmp++;
    if (grant !== 2'b00) begin
      n_bad++; $display("FAIL single_release: got %b want 00", grant);
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    go();
    s_ack = 1'b1;
    mid();
    n_cmp++;
    if ({grant, m_ack} !== 4'b0101) begin
      n_bad++; $display("FAIL coll_first: got %b want 0101", {grant, m_ack});
    end
    go();
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    go(); mid();
    n_cmp++;
    if (grant !== 2'b00) begin
      n_bad++; $display("FAIL coll_dead: got %b want 00", grant);
    end
    go(); mid();
    n_cmp++;
    if ({grant, s_cyc} !== 3'b101) begin
      n_bad++; $display("FAIL coll_second: got %b want 101", {grant, s_cyc});
    end
    idle_inputs();
  endtask

  task automatic test_fairness();
    logic [1:0] want;
    int g;
    int w;
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    for (int j = 0; j < 8; j++) begin
      g = j % 2;
      want = (g == 0) ? 2'b01 : 2'b10;
      w = 0;
      go();
      while (grant === 2'b00 && w < 10) begin
        go();
        w++;
      end
      n_cmp++;
      if (grant !== want) begin
        n_bad++; $display("FAIL fair_%0d: got %b want %b", j, grant, want);
      end
      s_ack = 1'b1;
      go();
      s_ack = 1'b0;
      m_cyc[g] = 1'b0; m_stb[g] = 1'b0;
      go();
      m_cyc[g] = 1'b1; m_stb[g] = 1'b1;
    end
    idle_inputs();
    go(); go();
  endtask

  task automatic test_burst();
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    go();
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1; s_dat_i = 32'hB000_0000 + b;
      mid();
      n_cmp++;
      if ({grant, m_ack} !== 4'b0101) begin
        n_bad++; $display("FAIL burst_beat%0d: got %b want 0101", b, {grant, m_ack});
      end
      go();
    end
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    go(); mid();
    n_cmp++;
    if (grant !== 2'b00) begin
      n_bad++; $display("FAIL burst_gap: got %b want 00", grant);
    end
    go(); mid();
    n_cmp++;
    if (grant !== 2'b10) begin
      n_bad++; $display("FAIL burst_next: got %b want 10", grant);
    end
    idle_inputs();
  endtask

  task automatic test_watchdog();
    logic [1:0] want;
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      mid();
      want = (n == 8) ? 2'b01 : 2'b00;
      n_cmp++;
      if ({m_err, m_ack} !== {want, 2'b00}) begin
        n_bad++; $display("FAIL wdt_cycle%0d: err/ack got %b want %b00", n, {m_err, m_ack}, want);
      end
      if (n < 8) go();
    end
    go();
    s_ack = 1'b1;
    mid();
    n_cmp++;
    if ({s_cyc, s_stb, m_ack, m_err, grant} !== 8'b00_00_00_01) begin
      n_bad++; $display("FAIL wdt_abort: got %b want 00000001", {s_cyc, s_stb, m_ack, m_err, grant});
    end
    go();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    go(); mid();
    n_cmp++;
    if (grant !== 2'b00) begin
      n_bad++; $display("FAIL wdt_free: got %b want 00", grant);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    go(); mid();
    n_cmp++;
    if ({grant, s_cyc} !== 3'b011) begin
      n_bad++; $display("FAIL rmid_busy: got %b want 011", {grant, s_cyc});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({grant, s_cyc} !== 3'b000) begin
      n_bad++; $display("FAIL rmid_async: got %b want 000", {grant, s_cyc});
    end
    m_cyc = 2'b11; m_stb = 2'b11;
    go();
    #3;
    rst_n = 1'b1;
    go(); mid();
    n_cmp++;
    if (grant !== 2'b01) begin
      n_bad++; $display("FAIL rmid_regrant: got %b want 01", grant);
    end
    idle_inputs();
    go(); go();
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [63:0] t64;
    logic [7:0]  t8;
    logic [1:0]  e_grant, e_ack, e_err;
    logic [2:0]  e_ctrl;
    logic [67:0] e_bus;
    bit live, ocyc, ostb;
    int ack_pct;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      ack_pct = ((n / 100) % 3 == 2) ? 0 : 50;
      for (int k = 0; k < NUM_M; k++) begin
        if (!m_cyc[k]) begin
          if ($urandom_range(0, 2) == 0) m_cyc[k] = 1'b1;
        end else if ($urandom_range(0, 11) == 0) begin
          m_cyc[k] = 1'b0; m_stb[k] = 1'b0;
        end
        if (m_cyc[k]) begin
          if (!m_stb[k]) m_stb[k] = ($urandom_range(0, 1) == 1);
          else if ($urandom_range(0, 7) == 0) m_stb[k] = 1'b0;
        end
        r = $urandom; m_we[k] = r[0];
        m_sel[4*k +: 4] = r[7:4];
        m_adr[32*k +: 32] = $urandom;
        m_dat[32*k +: 32] = $urandom;
      end
      s_ack = ($urandom_range(0, 99) < ack_pct);
      s_dat_i = $urandom;
      mid();
      e_grant = '0; e_ack = '0; e_err = '0; e_ctrl = '0; e_bus = '0;
      live = (own >= 0) && !aborted;
      if (own >= 0) e_grant = 2'(32'd1 << own);
      if (live) begin
        ocyc = ((m_cyc >> own) & 2'b01) != 2'b00;
        ostb = ((m_stb >> own) & 2'b01) != 2'b00;
        e_ctrl = {ocyc, ostb, ((m_we >> own) & 2'b01) != 2'b00};
        t64 = m_adr >> (32 * own); e_bus[67:36] = t64[31:0];
        t64 = m_dat >> (32 * own); e_bus[35:4] = t64[31:0];
        t8 = m_sel >> (4 * own); e_bus[3:0] = t8[3:0];
        if (ostb && s_ack) e_ack = e_grant;
        if (ostb && !s_ack && waited + 1 == TIMEOUT) e_err = e_grant;
      end
      n_cmp++;
      if (grant !== e_grant) begin
        n_bad++; $display("FAIL rnd_grant@%0d: got %b want %b", n, grant, e_grant);
      end
      n_cmp++;
      if ({s_cyc, s_stb, s_we} !== e_ctrl) begin
        n_bad++; $display("FAIL rnd_ctrl@%0d: got %b want %b", n, {s_cyc, s_stb, s_we}, e_ctrl);
      end
      n_cmp++;
      if ({s_adr, s_dat_o, s_sel} !== e_bus) begin
        n_bad++; $display("FAIL rnd_bus@%0d: got %h want %h", n, {s_adr, s_dat_o, s_sel}, e_bus);
      end
      n_cmp++;
      if ({m_ack, m_err} !== {e_ack, e_err}) begin
        n_bad++; $display("FAIL rnd_ackerr@%0d: got %b want %b", n, {m_ack, m_err}, {e_ack, e_err});
      end
      n_cmp++;
      if (o_m_dat !== s_dat_i) begin
        n_bad++; $display("FAIL rnd_rdata@%0d: got %h want %h", n, o_m_dat, s_dat_i);
      end
      n_cmp++;
      if (!$onehot0(grant) || !$onehot0(m_ack | m_err)) begin
        n_bad++; $display("FAIL rnd_onehot@%0d: grant %b ack|err %b want onehot0", n, grant, m_ack | m_err);
      end
      go();
    end
    idle_inputs();
    go(); go();
  endtask

  initial begin
    test_reset();
    test_single();
    test_collision();
    test_fairness();
    test_burst();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
